// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, NOP encoding, instruction-memory states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 16;

    // All-zero word decodes as a no-op on the core.
    localparam logic [CPU_DATA_W-1:0] CPU_NOP = 16'h0000;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Storage for instr_mem: DEPTH x WIDTH RAM, one write port, one registered read port.
// Latency: read data valid one clock after re; write lands on the same edge.
// Backpressure: none; caller guarantees addresses are in range.
//
// Ports:
//   clk          clock
//   we/waddr/wdata   write port
//   re/raddr     read request; rdata updates only when re=1 and holds otherwise
//   rdata        registered read data (not reset; contents survive reset)
module imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: sequential program-load port plus PC-addressed fetch.
// Latency: fetch accepted at edge N returns fetch_valid/instruction at edge N+1, 1/cycle.
// Backpressure: fetch_ready=0 while loading; requests then are dropped, not queued.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_req, pc         fetch request and word address (accepted when fetch_ready=1)
//   fetch_ready           high in RUN
//   fetch_valid           one-cycle pulse per accepted fetch
//   instruction           fetched word (NOP_WORD when out of range); holds between fetches
//   addr_fault            pulses with fetch_valid when pc >= DEPTH
//   ld_start/ld_we/ld_data/ld_done   program-load controls
//   ld_count, ld_overflow, loading   load status
//   parity_err            (INSTR_MEM_PARITY_EN only) pulses with fetch_valid on parity mismatch
//
// Build option: define INSTR_MEM_PARITY_EN to store an even-parity bit per word
// and add the parity_err output.
module instr_mem
    import cpu_pkg::*;
#(
    parameter int                  DATA_W       = CPU_DATA_W,
    parameter int                  ADDR_W       = CPU_ADDR_W,
    parameter int                  DEPTH        = 256,
    parameter logic [DATA_W-1:0]   NOP_WORD     = DATA_W'(CPU_NOP),
    parameter bit                  BOOT_IN_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              addr_fault,
    input  logic              ld_start,
    input  logic              ld_we,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic [ADDR_W-1:0] ld_count,
    output logic              ld_overflow,
`ifdef INSTR_MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              loading
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the pointer can sit at DEPTH even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    imem_state_t       state;
    logic [ADDR_W:0]   ld_ptr;
    logic              nop_sel;     // output mux selects NOP_WORD instead of RAM data
    logic              fetch_acc;
    logic              pc_oor;
    logic              wr_en;
    logic              rd_en;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    assign fetch_ready = (state == IMEM_RUN);
    assign loading     = (state == IMEM_LOAD);
    assign fetch_acc   = fetch_req && (state == IMEM_RUN);
    assign pc_oor      = ({1'b0, pc} >= DEPTH_X);

    // ld_start in LOAD restarts the load, so a coincident write is discarded.
    assign wr_en = !rst && (state == IMEM_LOAD) && ld_we && !ld_start && (ld_ptr < DEPTH_X);
    // Out-of-range fetches leave the RAM register untouched; the mux supplies NOP.
    assign rd_en = !rst && fetch_acc && !pc_oor;

`ifdef INSTR_MEM_PARITY_EN
    assign wr_word = {^ld_data, ld_data};
`else
    assign wr_word = ld_data;
`endif

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (ld_ptr[IDX_W-1:0]),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (pc[IDX_W-1:0]),
        .rdata (rd_word)
    );

    assign instruction = nop_sel ? NOP_WORD : rd_word[DATA_W-1:0];
    assign ld_count    = ld_ptr[ADDR_W-1:0];

`ifdef INSTR_MEM_PARITY_EN
    // Stored word including its parity bit must XOR to zero.
    assign parity_err = fetch_valid && !addr_fault && (^rd_word);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT_IN_LOAD ? IMEM_LOAD : IMEM_RUN;
            fetch_valid <= 1'b0;
            addr_fault  <= 1'b0;
            nop_sel     <= 1'b1;
            ld_ptr      <= '0;
            ld_overflow <= 1'b0;
        end else begin
            fetch_valid <= fetch_acc;
            addr_fault  <= fetch_acc && pc_oor;
            if (fetch_acc) begin
                nop_sel <= pc_oor;
            end

            case (state)
                IMEM_LOAD: begin
                    if (ld_start) begin
                        ld_ptr      <= '0;
                        ld_overflow <= 1'b0;
                    end else begin
                        if (ld_we) begin
                            if (ld_ptr < DEPTH_X) begin
                                ld_ptr <= ld_ptr + 1'b1;
                            end else begin
                                ld_overflow <= 1'b1;
                            end
                        end
                        if (ld_done) begin
                            state <= IMEM_RUN;
                        end
                    end
                end
                IMEM_RUN: begin
                    if (ld_start) begin
                        state       <= IMEM_LOAD;
                        ld_ptr      <= '0;
                        ld_overflow <= 1'b0;
                    end
                end
                default: state <= IMEM_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: DUT A (DEPTH=256, boots in LOAD), DUT B (DEPTH=4, boots in RUN, NOP=F00F).
// Inputs driven on the falling edge; outputs checked on the falling edge after the active edge.
// Parity checks are compiled in with INSTR_MEM_PARITY_EN.
module tb_instr_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A ----------------
    logic        a_rst = 1'b1, a_req = 1'b0, a_start = 1'b0, a_we = 1'b0, a_done = 1'b0;
    logic [15:0] a_pc = '0, a_data = '0;
    logic        a_ready, a_valid, a_fault, a_ovf, a_loading;
    logic [15:0] a_instr, a_count;
`ifdef INSTR_MEM_PARITY_EN
    logic        a_perr, b_perr;
`endif

    instr_mem #(.DEPTH(256), .NOP_WORD(16'h0000), .BOOT_IN_LOAD(1'b1)) dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .fetch_req   (a_req),
        .pc          (a_pc),
        .fetch_ready (a_ready),
        .fetch_valid (a_valid),
        .instruction (a_instr),
        .addr_fault  (a_fault),
        .ld_start    (a_start),
        .ld_we       (a_we),
        .ld_data     (a_data),
        .ld_done     (a_done),
        .ld_count    (a_count),
        .ld_overflow (a_ovf),
`ifdef INSTR_MEM_PARITY_EN
        .parity_err  (a_perr),
`endif
        .loading     (a_loading)
    );

    // ---------------- DUT B ----------------
    logic        b_rst = 1'b1, b_req = 1'b0, b_start = 1'b0, b_we = 1'b0, b_done = 1'b0;
    logic [15:0] b_pc = '0, b_data = '0;
    logic        b_ready, b_valid, b_fault, b_ovf, b_loading;
    logic [15:0] b_instr, b_count;

    instr_mem #(.DEPTH(4), .NOP_WORD(16'hF00F), .BOOT_IN_LOAD(1'b0)) dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .fetch_req   (b_req),
        .pc          (b_pc),
        .fetch_ready (b_ready),
        .fetch_valid (b_valid),
        .instruction (b_instr),
        .addr_fault  (b_fault),
        .ld_start    (b_start),
        .ld_we       (b_we),
        .ld_data     (b_data),
        .ld_done     (b_done),
        .ld_count    (b_count),
        .ld_overflow (b_ovf),
`ifdef INSTR_MEM_PARITY_EN
        .parity_err  (b_perr),
`endif
        .loading     (b_loading)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        fault;
    } fvec_t;

    logic [15:0] prog [6];
    fvec_t       tbl  [9];
    logic [15:0] rpc  [4];
    logic [15:0] rexp [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        prog[0] = 16'h0298; prog[1] = 16'h9605; prog[2] = 16'h8085;
        prog[3] = 16'h1111; prog[4] = 16'h1248; prog[5] = 16'h08D0;

        tbl[0] = '{16'h0000, 16'h0298, 1'b0};
        tbl[1] = '{16'h0001, 16'h9605, 1'b0};
        tbl[2] = '{16'h0002, 16'h8085, 1'b0};
        tbl[3] = '{16'h0003, 16'h1111, 1'b0};
        tbl[4] = '{16'h0004, 16'h1248, 1'b0};
        tbl[5] = '{16'h0005, 16'h08D0, 1'b0};
        tbl[6] = '{16'h0100, 16'h0000, 1'b1};
        tbl[7] = '{16'hFFFF, 16'h0000, 1'b1};
        tbl[8] = '{16'h0002, 16'h8085, 1'b0};

        // ---- A: reset values ----
        repeat (2) @(negedge clk);
        chkb("a_rst_loading", a_loading, 1'b1);
        chkb("a_rst_ready",   a_ready,   1'b0);
        chkb("a_rst_valid",   a_valid,   1'b0);
        chk ("a_rst_instr",   a_instr,   16'h0000);
        chkb("a_rst_fault",   a_fault,   1'b0);
        chk ("a_rst_count",   a_count,   16'd0);
        chkb("a_rst_ovf",     a_ovf,     1'b0);

        // ---- A: boot load of 6 words, with an ignored fetch in LOAD ----
        a_rst = 1'b0;
        a_we = 1'b1; a_data = prog[0];
        a_req = 1'b1; a_pc = 16'h0000;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) chkb("a_load_fetch_ignored", a_valid, 1'b0);
            a_req = 1'b0;
            a_data = prog[i];
        end
        @(negedge clk);
        a_we = 1'b0; a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        chk ("a_boot_count",   a_count,   16'd6);
        chkb("a_boot_loading", a_loading, 1'b0);
        chkb("a_boot_ready",   a_ready,   1'b1);

        // ---- A: back-to-back fetch table incl. out-of-range ----
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chkb("a_tbl_valid", a_valid, 1'b1);
                chk ("a_tbl_instr", a_instr, tbl[i-1].instr);
                chkb("a_tbl_fault", a_fault, tbl[i-1].fault);
            end
            a_req = 1'b1; a_pc = tbl[i].pc;
        end
        @(negedge clk);
        chkb("a_tbl_valid", a_valid, 1'b1);
        chk ("a_tbl_instr", a_instr, tbl[8].instr);
        chkb("a_tbl_fault", a_fault, tbl[8].fault);
        a_req = 1'b0;
        @(negedge clk);
        chkb("a_idle_valid", a_valid, 1'b0);
        chkb("a_idle_fault", a_fault, 1'b0);
        chk ("a_idle_hold",  a_instr, 16'h8085);

        // ---- A: ld_start with a concurrent fetch, then fetch ignored ----
        a_start = 1'b1; a_req = 1'b1; a_pc = 16'h0002;
        @(negedge clk);
        chkb("a_reload_valid",   a_valid,   1'b1);
        chk ("a_reload_instr",   a_instr,   16'h8085);
        chkb("a_reload_loading", a_loading, 1'b1);
        chkb("a_reload_ready",   a_ready,   1'b0);
        chk ("a_reload_count",   a_count,   16'd0);
        a_start = 1'b0; a_pc = 16'h0003;
        @(negedge clk);
        chkb("a_reload_fetch_ignored", a_valid, 1'b0);
        a_req = 1'b0;

        // ---- A: full 256-word load, then one overflowing write ----
        for (int i = 0; i < 256; i++) begin
            a_we = 1'b1;
            a_data = (i < 6) ? prog[i] : (16'hA000 | 16'(i));
            @(negedge clk);
        end
        chk ("a_full_count", a_count, 16'd256);
        chkb("a_full_ovf",   a_ovf,   1'b0);
        a_data = 16'hDEAD;
        @(negedge clk);
        chk ("a_ovf_count", a_count, 16'd256);
        chkb("a_ovf_flag",  a_ovf,   1'b1);
        a_we = 1'b0; a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        chkb("a_ovf_sticky", a_ovf, 1'b1);
        a_req = 1'b1; a_pc = 16'h00FF;
        @(negedge clk);
        chkb("a_last_valid", a_valid, 1'b1);
        chk ("a_last_instr", a_instr, 16'hA0FF);
        chkb("a_last_fault", a_fault, 1'b0);
        a_pc = 16'h0100;
        @(negedge clk);
        chk ("a_oor_instr", a_instr, 16'h0000);
        chkb("a_oor_fault", a_fault, 1'b1);
        a_req = 1'b0;
        @(negedge clk);
        chkb("a_oor_pulse", a_fault, 1'b0);

        // ---- A: reset mid-load ----
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_we = 1'b1; a_data = 16'hBEEF;
        @(negedge clk);
        a_data = 16'hCAFE;
        @(negedge clk);
        a_data = 16'hDEAD; a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0; a_we = 1'b0;
        chkb("a_mid_loading", a_loading, 1'b1);
        chk ("a_mid_count",   a_count,   16'd0);
        chkb("a_mid_ovf",     a_ovf,     1'b0);
        chkb("a_mid_valid",   a_valid,   1'b0);
        chk ("a_mid_instr",   a_instr,   16'h0000);
        chkb("a_mid_ready",   a_ready,   1'b0);

        // ---- A: reset in the same cycle as a fetch drops the valid ----
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0; a_req = 1'b1; a_pc = 16'h0002; a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0; a_req = 1'b0;
        chkb("a_rstfetch_valid",   a_valid,   1'b0);
        chkb("a_rstfetch_loading", a_loading, 1'b1);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;

        // ---- A: memory contents survive reset ----
        rpc[0] = 16'h0000; rexp[0] = 16'hBEEF;
        rpc[1] = 16'h0001; rexp[1] = 16'hCAFE;
        rpc[2] = 16'h0002; rexp[2] = 16'h8085;
        rpc[3] = 16'h00FF; rexp[3] = 16'hA0FF;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_pc = rpc[i];
            @(negedge clk);
            chkb("a_keep_valid", a_valid, 1'b1);
            chk ("a_keep_instr", a_instr, rexp[i]);
        end
        a_req = 1'b0;

`ifdef INSTR_MEM_PARITY_EN
        // ---- A: parity injection on word 3 (16'h1111, stored parity 0) ----
        force dut_a.u_array.mem[3][16] = 1'b1;
        a_req = 1'b1; a_pc = 16'h0003;
        @(negedge clk);
        chkb("a_par_err3",   a_perr,  1'b1);
        chkb("a_par_valid3", a_valid, 1'b1);
        chk ("a_par_instr3", a_instr, 16'h1111);
        a_pc = 16'h0002;
        @(negedge clk);
        chkb("a_par_err2",   a_perr,  1'b0);
        chk ("a_par_instr2", a_instr, 16'h8085);
        a_pc = 16'h0100;
        @(negedge clk);
        chkb("a_par_oor", a_perr, 1'b0);
        a_req = 1'b0;
        release dut_a.u_array.mem[3][16];
        @(negedge clk);
`endif

        // ---- B: DEPTH=4, boots in RUN ----
        chkb("b_rst_loading", b_loading, 1'b0);
        chkb("b_rst_ready",   b_ready,   1'b1);
        chk ("b_rst_instr",   b_instr,   16'hF00F);
        chk ("b_rst_count",   b_count,   16'd0);
        b_rst = 1'b0;
        // ld_start and ld_done together: ld_start wins
        b_start = 1'b1; b_done = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_done = 1'b0;
        chkb("b_start_wins", b_loading, 1'b1);
        for (int i = 0; i < 5; i++) begin
            b_we = 1'b1; b_data = 16'hB000 + 16'(i);
            @(negedge clk);
        end
        chk ("b_ovf_count", b_count, 16'd4);
        chkb("b_ovf_flag",  b_ovf,   1'b1);
        b_we = 1'b0; b_done = 1'b1;
        @(negedge clk);
        b_done = 1'b0; b_req = 1'b1; b_pc = 16'h0003;
        @(negedge clk);
        chk ("b_word3", b_instr, 16'hB003);
        b_pc = 16'h0004;
        @(negedge clk);
        chk ("b_oor_instr", b_instr, 16'hF00F);
        chkb("b_oor_fault", b_fault, 1'b1);
        b_req = 1'b0; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chkb("b_reenter_loading", b_loading, 1'b1);
        chk ("b_reenter_count",   b_count,   16'd0);
        chkb("b_reenter_ovf",     b_ovf,     1'b0);
        b_we = 1'b1; b_data = 16'hC000;
        @(negedge clk);
        b_data = 16'hC001;
        @(negedge clk);
        b_data = 16'hC002; b_done = 1'b1;
        @(negedge clk);
        b_we = 1'b0; b_done = 1'b0;
        chkb("b_wedone_loading", b_loading, 1'b0);
        chk ("b_wedone_count",   b_count,   16'd3);
        b_req = 1'b1; b_pc = 16'h0002;
        @(negedge clk);
        chk ("b_wedone_word", b_instr, 16'hC002);
        b_pc = 16'h0003;
        @(negedge clk);
        chk ("b_old_word3", b_instr, 16'hB003);
        b_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
